// File: rtl/ip_rewrite_manager_pkg.sv
// Shared types and constants for the rewrite-table manager logic.
// The update-channel arbiter uses these to share one NoC update port.
package ip_rewrite_manager_pkg;

  // Default number of cycles to wait for an ack before returning an error response.
  localparam int ARB_TIMEOUT_DEFAULT = 1024;

  // Update-channel arbiter states.
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_FWD      = 2'd1,
    ARB_WAIT_ACK = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_e;

  // Advance a round-robin pointer by one position, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ip_rewrite_rr_arb.sv
// Combinational round-robin picker: selects the lowest requesting index at or
// above ptr, wrapping around, and returns it as both one-hot and encoded index.
module ip_rewrite_rr_arb
  import ip_rewrite_manager_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_oh,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Scan from ptr upward, wrapping, and take the first active request.
  always_comb begin
    // NOTE: every output gets a default first so no path through the loop leaves a latch.
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ip_rewrite_update_arbiter.sv
// Shares one rewrite-table update channel (NoC out + ack NoC in) among several
// manager controllers. A grant covers the whole message and its ack, so neither
// flits nor acks of different requesters ever interleave.
module ip_rewrite_update_arbiter
  import ip_rewrite_manager_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 512,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_val,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      noc_out_val,
  output logic [DATA_W-1:0]         noc_out_data,
  input  logic                      noc_out_rdy,
  input  logic                      noc_in_val,
  input  logic [DATA_W-1:0]         noc_in_data,
  output logic                      noc_in_rdy,
  output logic [NUM_REQ-1:0]        resp_val,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  input  logic [NUM_REQ-1:0]        resp_rdy,
  output logic                      stray_ack
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state;
  logic [IDX_W-1:0]   grant;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   ptr;
  logic [TMR_W-1:0]   timer;
  logic [DATA_W-1:0]  resp_data_q;
  logic               resp_err_q;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               fwd_hs;

  ip_rewrite_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req       (req_val),
    .ptr       (ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // A flit of the granted requester is accepted by the NoC this cycle.
  assign fwd_hs = (state == ARB_FWD) && req_val[grant] && noc_out_rdy;

  // Response register is held at zero while reset is applied.
  assign resp_data = rst ? '0 : resp_data_q;
  assign resp_err  = rst ? 1'b0 : resp_err_q;

  // Per-state handshake outputs; everything is quiet while reset is asserted.
  always_comb begin
    req_rdy      = '0;
    noc_out_val  = 1'b0;
    noc_out_data = '0;
    noc_in_rdy   = 1'b0;
    resp_val     = '0;
    stray_ack    = 1'b0;
    if (!rst) begin
      case (state)
        ARB_IDLE: begin
          // Nobody is waiting for an ack here, so anything arriving is dropped.
          noc_in_rdy = 1'b1;
          stray_ack  = noc_in_val;
        end
        ARB_FWD: begin
          noc_out_val  = req_val[grant];
          noc_out_data = req_data[grant*DATA_W +: DATA_W];
          req_rdy      = noc_out_rdy ? grant_oh : '0;
        end
        ARB_WAIT_ACK: noc_in_rdy = 1'b1;
        ARB_RESP:     resp_val   = grant_oh;
        default: ;
      endcase
    end
  end

  // FSM, grant/pointer/timer registers and the response register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_oh    <= '0;
      ptr         <= '0;
      timer       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (arb_any) begin
            grant    <= arb_idx;
            grant_oh <= arb_oh;
            ptr      <= IDX_W'(rr_next(int'(arb_idx), NUM_REQ));
            state    <= ARB_FWD;
          end
        end
        ARB_FWD: begin
          if (fwd_hs && req_last[grant]) begin
            timer <= '0;
            state <= ARB_WAIT_ACK;
          end
        end
        ARB_WAIT_ACK: begin
          // A real ack takes priority over an expiring timer.
          if (noc_in_val) begin
            resp_data_q <= noc_in_data;
            resp_err_q  <= 1'b0;
            state       <= ARB_RESP;
          end else if (timer == TIMER_LAST) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
            state       <= ARB_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ARB_RESP: begin
          if (resp_rdy[grant]) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_rewrite_update_arbiter.sv
// Directed bench for the update-channel arbiter: a table of single messages
// (requester mask, flit count, expected grant, ack delay) plus hand-written
// sequences for timeout, ack on the final timer cycle and reset mid-message.
module tb_ip_rewrite_update_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int NV = 23;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_val;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_rdy;
  logic            noc_out_val;
  logic [DW-1:0]   noc_out_data;
  logic            noc_out_rdy;
  logic            noc_in_val;
  logic [DW-1:0]   noc_in_data;
  logic            noc_in_rdy;
  logic [NR-1:0]   resp_val;
  logic [DW-1:0]   resp_data;
  logic            resp_err;
  logic [NR-1:0]   resp_rdy;
  logic            stray_ack;

  ip_rewrite_update_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_val      (req_val),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_rdy      (req_rdy),
    .noc_out_val  (noc_out_val),
    .noc_out_data (noc_out_data),
    .noc_out_rdy  (noc_out_rdy),
    .noc_in_val   (noc_in_val),
    .noc_in_data  (noc_in_data),
    .noc_in_rdy   (noc_in_rdy),
    .resp_val     (resp_val),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .resp_rdy     (resp_rdy),
    .stray_ack    (stray_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] mask;   // requesters holding a message
    int            nfl;    // flits per message
    int            g;      // expected grant index
    bit            tog;    // toggle noc_out_rdy every cycle
    int            dly;    // cycles from last flit to ack injection
    logic [DW-1:0] ack;    // ack flit value
  } vec_t;

  vec_t vecs[NV];
  int   checks   = 0;
  int   failures = 0;
  int   cur_vec  = -1;
  int   fcnt[NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_vec, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit_word(input int i, input int f);
    return {8'hC0 + i[7:0], f[7:0], 16'h5A5A};
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] one;
    one = 1;
    return one << g;
  endfunction

  // Present each requester's current flit according to its own flit counter.
  task automatic drive_flits(input int n);
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = flit_word(i, fcnt[i]);
      req_last[i]          = (fcnt[i] == n - 1);
    end
  endtask

  // All outputs idle with noc_in_rdy at the given value.
  task automatic check_quiet(input string name, input logic in_rdy);
    check({name, "_ctl"}, {56'd0, noc_out_val, req_rdy, resp_val, resp_err, stray_ack},
          64'd0);
    check({name, "_in_rdy"}, {63'd0, noc_in_rdy}, {63'd0, in_rdy});
    check({name, "_data"}, {noc_out_data, resp_data}, 64'd0);
  endtask

  // Offer messages from every requester in mask; check the IDLE bubble, the
  // grant, flit order and req_rdy until the granted requester's last flit.
  // Returns sitting in the negedge of the last-flit handshake.
  task automatic send_msg(input logic [NR-1:0] mask, input int n, input int g, input bit tog);
    int  cyc;
    bit  done;
    for (int i = 0; i < NR; i++) fcnt[i] = 0;
    @(negedge clk);
    req_val     = mask;
    noc_out_rdy = !tog;
    drive_flits(n);
    #1;
    check("idle_bubble", {60'd0, noc_out_val, req_rdy[2:0]} | {60'd0, req_rdy[3], 3'd0}, 64'd0);
    cyc  = 0;
    done = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      noc_out_rdy = tog ? cyc[0] : 1'b1;
      drive_flits(n);
      #1;
      check("fwd_val", {63'd0, noc_out_val}, 64'd1);
      check("req_rdy", {60'd0, req_rdy}, {60'd0, (noc_out_rdy ? onehot(g) : 4'b0)});
      if (noc_out_val && noc_out_rdy) begin
        check("flit_data", {32'd0, noc_out_data}, {32'd0, flit_word(g, fcnt[g])});
        if (fcnt[g] == n - 1) done = 1;
        fcnt[g]++;
      end
    end
    if (!done) check("msg_complete", 64'd0, 64'd1);
  endtask

  // Inject the ack dly cycles after the last flit, then check and consume the response.
  task automatic ack_and_resp(input int g, input logic [DW-1:0] ack, input int dly);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      if (d == 0) begin
        req_val     = '0;
        noc_out_rdy = 1'b1;
      end
    end
    #1;
    check("wait_no_resp", {60'd0, resp_val}, 64'd0);
    check("wait_in_rdy", {63'd0, noc_in_rdy}, 64'd1);
    noc_in_val  = 1'b1;
    noc_in_data = ack;
    @(negedge clk);
    noc_in_val  = 1'b0;
    noc_in_data = '0;
    #1;
    check("resp_val", {60'd0, resp_val}, {60'd0, onehot(g)});
    check("resp_err", {63'd0, resp_err}, 64'd0);
    check("resp_data", {32'd0, resp_data}, {32'd0, ack});
    @(negedge clk);
    #1;
    check("resp_hold", {60'd0, resp_val}, {60'd0, onehot(g)});
    resp_rdy = onehot(g);
    @(negedge clk);
    resp_rdy = '0;
    #1;
    check("resp_done", {60'd0, resp_val, noc_in_rdy}, {60'd0, 4'b0, 1'b1});
  endtask

  initial begin
    int cnt;
    bit seen;
    vecs[0]  = '{4'b0001, 2, 0, 1'b0, 5, 32'hA0C0_0000};
    vecs[1]  = '{4'b1000, 1, 3, 1'b0, 1, 32'hA0C0_0001};
    vecs[2]  = '{4'b1111, 2, 0, 1'b0, 2, 32'hA0C0_0002};
    vecs[3]  = '{4'b1111, 2, 1, 1'b0, 3, 32'hA0C0_0003};
    vecs[4]  = '{4'b1111, 2, 2, 1'b0, 1, 32'hA0C0_0004};
    vecs[5]  = '{4'b1111, 2, 3, 1'b0, 4, 32'hA0C0_0005};
    vecs[6]  = '{4'b1111, 1, 0, 1'b0, 2, 32'hA0C0_0006};
    vecs[7]  = '{4'b1111, 3, 1, 1'b0, 1, 32'hA0C0_0007};
    vecs[8]  = '{4'b1111, 1, 2, 1'b0, 3, 32'hA0C0_0008};
    vecs[9]  = '{4'b1111, 2, 3, 1'b0, 2, 32'hA0C0_0009};
    vecs[10] = '{4'b1111, 3, 0, 1'b0, 1, 32'hA0C0_000A};
    vecs[11] = '{4'b1111, 2, 1, 1'b0, 5, 32'hA0C0_000B};
    vecs[12] = '{4'b1111, 1, 2, 1'b0, 2, 32'hA0C0_000C};
    vecs[13] = '{4'b1111, 2, 3, 1'b0, 1, 32'hA0C0_000D};
    vecs[14] = '{4'b0001, 1, 0, 1'b0, 2, 32'hA0C0_000E};
    vecs[15] = '{4'b0001, 3, 0, 1'b0, 3, 32'hA0C0_000F};
    vecs[16] = '{4'b1010, 2, 1, 1'b0, 1, 32'hA0C0_0010};
    vecs[17] = '{4'b1010, 1, 3, 1'b0, 2, 32'hA0C0_0011};
    vecs[18] = '{4'b0100, 2, 2, 1'b0, 4, 32'hA0C0_0012};
    vecs[19] = '{4'b0011, 1, 0, 1'b0, 1, 32'hA0C0_0013};
    vecs[20] = '{4'b1001, 2, 3, 1'b0, 2, 32'hA0C0_0014};
    vecs[21] = '{4'b0100, 3, 2, 1'b1, 3, 32'hA0C0_0015};
    vecs[22] = '{4'b1111, 3, 3, 1'b1, 2, 32'hA0C0_0016};

    rst         = 1'b1;
    req_val     = '0;
    req_data    = '0;
    req_last    = '0;
    noc_out_rdy = 1'b1;
    noc_in_val  = 1'b1;
    noc_in_data = 32'hFFFF_FFFF;
    resp_rdy    = '0;

    // Reset: everything is 0, even with an ack offered.
    repeat (3) @(negedge clk);
    #1;
    check_quiet("in_reset", 1'b0);
    @(negedge clk);
    rst         = 1'b0;
    noc_in_val  = 1'b0;
    noc_in_data = '0;
    #1;
    check_quiet("after_reset", 1'b1);

    // Table: arbitration order, flit passthrough and ack delivery.
    for (int k = 0; k < NV; k++) begin
      cur_vec = k;
      send_msg(vecs[k].mask, vecs[k].nfl, vecs[k].g, vecs[k].tog);
      ack_and_resp(vecs[k].g, vecs[k].ack, vecs[k].dly);
    end

    // Timeout: no ack -> error response 16 edges after the last flit's edge.
    cur_vec = 100;
    send_msg(4'b0010, 1, 1, 1'b0);
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) req_val = '0;
      #1;
      if (resp_val != '0) seen = 1;
    end
    // First negedge after the accepting edge is cnt=1, so 16 edges later is cnt=17.
    check("timeout_latency", 64'(cnt), 64'd17);
    check("timeout_val", {60'd0, resp_val}, {60'd0, 4'b0010});
    check("timeout_err", {63'd0, resp_err}, 64'd1);
    check("timeout_data", {32'd0, resp_data}, 64'd0);
    @(negedge clk);
    resp_rdy = 4'b0010;
    @(negedge clk);
    resp_rdy    = '0;
    noc_in_val  = 1'b1;
    noc_in_data = 32'hDEAD_0001;
    #1;
    check("late_ack_stray", {63'd0, stray_ack}, 64'd1);
    check("late_ack_in_rdy", {63'd0, noc_in_rdy}, 64'd1);
    @(negedge clk);
    noc_in_val  = 1'b0;
    noc_in_data = '0;
    #1;
    check("late_ack_pulse", {63'd0, stray_ack}, 64'd0);
    check("late_ack_dropped", {27'd0, resp_val, resp_err, resp_data}, {27'd0, 4'b0, 1'b1, 32'd0});

    // Ack on the last timer cycle wins over the timeout.
    cur_vec = 101;
    send_msg(4'b0010, 1, 1, 1'b0);
    ack_and_resp(1, 32'h0BAD_F00D, TO);

    // Reset while forwarding: outputs clear, pointer restarts at 0.
    cur_vec = 102;
    for (int i = 0; i < NR; i++) fcnt[i] = 0;
    @(negedge clk);
    req_val     = 4'b1111;
    noc_out_rdy = 1'b1;
    drive_flits(3);
    @(negedge clk);
    #1;
    check("pre_rst_fwd", {59'd0, noc_out_val, req_rdy}, {59'd0, 1'b1, 4'b0100});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("rst_in_fwd", 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    req_val = '0;
    #1;
    check_quiet("rst_idle", 1'b1);
    send_msg(4'b1111, 1, 0, 1'b0);
    ack_and_resp(0, 32'h5EED_0000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound in case a sequence stops making progress.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
